// File: rtl/commit_unit.sv
// Commit stage: retires up to two graduation-list slots per cycle, serialises
// CSR/fence ops through a req/ack handshake, and raises traps or redirects.
module commit_unit #(
  parameter  int NUM_GL_ENTRIES = 32,
  parameter  int PC_W           = 40,
  localparam int GL_IDX_W       = $clog2(NUM_GL_ENTRIES)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [1:0]          gl_valid_i,
  input  logic [1:0]          gl_is_store_i,
  input  logic [1:0]          gl_is_serial_i,
  input  logic [1:0]          gl_ex_valid_i,
  input  logic [5:0]          gl_ex_cause_i,
  input  logic [2*PC_W-1:0]   gl_pc_i,
  input  logic [GL_IDX_W-1:0] gl_head_i,
  output logic [1:0]          read_head_o,
  output logic                st_commit_valid_o,
  input  logic                st_commit_ready_i,
  output logic [GL_IDX_W-1:0] st_commit_idx_o,
  output logic                csr_req_o,
  input  logic                csr_ack_i,
  input  logic                csr_xcpt_i,
  input  logic [PC_W-1:0]     tvec_i,
  output logic                flush_commit_o,
  output logic                redirect_valid_o,
  output logic [PC_W-1:0]     redirect_pc_o,
  output logic                trap_o,
  output logic [5:0]          trap_cause_o,
  output logic [63:0]         instret_o
);

  typedef enum logic [1:0] {RUN, SER_WAIT, FLUSH} state_e;

  state_e          state_q, state_d;
  logic            csr_req_q, csr_req_d;
  logic            trap_q, trap_d;
  logic [5:0]      cause_q, cause_d;
  logic [PC_W-1:0] redir_q, redir_d;
  logic [63:0]     instret_q, instret_d;
  logic [1:0]      retire;
  logic            slot0_ok;

  // Slot-1 PC is never a redirect source.
  logic unused_pc1;
  assign unused_pc1 = ^gl_pc_i[2*PC_W-1:PC_W];

  assign slot0_ok = gl_valid_i[0] & ~gl_ex_valid_i[0] & ~gl_is_serial_i[0];

  always_comb begin
    state_d   = state_q;
    csr_req_d = csr_req_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    redir_d   = redir_q;
    retire    = '0;
    unique case (state_q)
      RUN: begin
        retire[0] = slot0_ok & (~gl_is_store_i[0] | st_commit_ready_i);
        retire[1] = retire[0] & gl_valid_i[1] & ~gl_is_store_i[1]
                  & ~gl_is_serial_i[1] & ~gl_ex_valid_i[1];
        if (gl_valid_i[0] & gl_ex_valid_i[0]) begin
          state_d = FLUSH;
          trap_d  = 1'b1;
          cause_d = gl_ex_cause_i;
          redir_d = tvec_i;
        end else if (gl_valid_i[0] & gl_is_serial_i[0]) begin
          state_d   = SER_WAIT;
          csr_req_d = 1'b1;
        end
      end
      SER_WAIT: begin
        if (csr_ack_i) begin
          state_d   = FLUSH;
          csr_req_d = 1'b0;
          if (csr_xcpt_i) begin
            trap_d  = 1'b1;
            cause_d = 6'd2;
            redir_d = tvec_i;
          end else begin
            retire  = 2'b01;
            trap_d  = 1'b0;
            redir_d = gl_pc_i[PC_W-1:0] + PC_W'(4);
          end
        end
      end
      FLUSH: begin
        state_d = RUN;
        trap_d  = 1'b0;
        cause_d = '0;
        redir_d = '0;
      end
      default: state_d = RUN;
    endcase
    instret_d = instret_q + 64'(retire[0]) + 64'(retire[1]);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= RUN;
      csr_req_q <= 1'b0;
      trap_q    <= 1'b0;
      cause_q   <= '0;
      redir_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      csr_req_q <= csr_req_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      redir_q   <= redir_d;
      instret_q <= instret_d;
    end
  end

  assign read_head_o       = retire;
  assign st_commit_valid_o = (state_q != FLUSH) & slot0_ok & gl_is_store_i[0];
  assign st_commit_idx_o   = gl_head_i;
  assign csr_req_o         = csr_req_q;
  assign flush_commit_o    = (state_q == FLUSH);
  assign redirect_valid_o  = (state_q == FLUSH);
  assign redirect_pc_o     = redir_q;
  assign trap_o            = trap_q;
  assign trap_cause_o      = cause_q;
  assign instret_o         = instret_q;

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: vector table, directed multi-cycle
// sequences, then random traffic against a behavioural model.
module tb_commit_unit;
  localparam int NGL  = 32;
  localparam int PC_W = 40;
  localparam int IW   = $clog2(NGL);

  logic            clk = 1'b0;
  logic            rstn;
  logic [1:0]      v, st, ser, ex;
  logic [5:0]      cause;
  logic [PC_W-1:0] pc0, pc1, tvec;
  logic [IW-1:0]   head;
  logic            rdy, ack, xcpt;
  logic [1:0]      read_head;
  logic            st_valid, csr_req, flush, rvalid, trap;
  logic [IW-1:0]   st_idx;
  logic [PC_W-1:0] rpc;
  logic [5:0]      tcause;
  logic [63:0]     instret;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_cnt;

  always #5 clk = ~clk;

  commit_unit #(.NUM_GL_ENTRIES(NGL), .PC_W(PC_W)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .gl_valid_i(v), .gl_is_store_i(st), .gl_is_serial_i(ser), .gl_ex_valid_i(ex),
    .gl_ex_cause_i(cause), .gl_pc_i({pc1, pc0}), .gl_head_i(head),
    .read_head_o(read_head), .st_commit_valid_o(st_valid), .st_commit_ready_i(rdy),
    .st_commit_idx_o(st_idx), .csr_req_o(csr_req), .csr_ack_i(ack), .csr_xcpt_i(xcpt),
    .tvec_i(tvec), .flush_commit_o(flush), .redirect_valid_o(rvalid),
    .redirect_pc_o(rpc), .trap_o(trap), .trap_cause_o(tcause), .instret_o(instret)
  );

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  task automatic clr();
    v = '0; st = '0; ser = '0; ex = '0; cause = '0;
    pc0 = '0; pc1 = '0; tvec = '0; head = '0;
    rdy = 1'b0; ack = 1'b0; xcpt = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 2 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] v, st, ser, ex;
    logic       rdy;
    logic [1:0] rh;
    logic       sv;
  } vec_t;

  vec_t tbl[11];

  // Behavioural model state for the random phase.
  logic            m_wait, m_flush, m_trap;
  logic [5:0]      m_cause;
  logic [PC_W-1:0] m_target;
  int              n_ret;

  initial begin
    tbl[0]  = '{v:2'b11, st:2'b00, ser:2'b00, ex:2'b00, rdy:1'b0, rh:2'b11, sv:1'b0};
    tbl[1]  = '{v:2'b01, st:2'b00, ser:2'b00, ex:2'b00, rdy:1'b0, rh:2'b01, sv:1'b0};
    tbl[2]  = '{v:2'b00, st:2'b00, ser:2'b00, ex:2'b00, rdy:1'b1, rh:2'b00, sv:1'b0};
    tbl[3]  = '{v:2'b10, st:2'b00, ser:2'b00, ex:2'b00, rdy:1'b1, rh:2'b00, sv:1'b0};
    tbl[4]  = '{v:2'b11, st:2'b01, ser:2'b00, ex:2'b00, rdy:1'b0, rh:2'b00, sv:1'b1};
    tbl[5]  = '{v:2'b11, st:2'b01, ser:2'b00, ex:2'b00, rdy:1'b1, rh:2'b11, sv:1'b1};
    tbl[6]  = '{v:2'b11, st:2'b10, ser:2'b00, ex:2'b00, rdy:1'b1, rh:2'b01, sv:1'b0};
    tbl[7]  = '{v:2'b11, st:2'b00, ser:2'b10, ex:2'b00, rdy:1'b0, rh:2'b01, sv:1'b0};
    tbl[8]  = '{v:2'b11, st:2'b00, ser:2'b00, ex:2'b10, rdy:1'b0, rh:2'b01, sv:1'b0};
    tbl[9]  = '{v:2'b01, st:2'b01, ser:2'b00, ex:2'b00, rdy:1'b1, rh:2'b01, sv:1'b1};
    tbl[10] = '{v:2'b10, st:2'b01, ser:2'b00, ex:2'b00, rdy:1'b1, rh:2'b00, sv:1'b0};

    clr();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_read_head", 64'(read_head), 0);
    chk("rst_instret", instret, 0);
    chk("rst_csr_req", 64'(csr_req), 0);
    chk("rst_flush", 64'(flush), 0);
    chk("rst_trap", 64'(trap), 0);
    chk("rst_redirect_pc", 64'(rpc), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_cnt = 0;

    // Single-cycle vectors that never leave RUN.
    for (int i = 0; i < 11; i++) begin
      v = tbl[i].v; st = tbl[i].st; ser = tbl[i].ser; ex = tbl[i].ex;
      rdy = tbl[i].rdy; head = IW'(i + 3);
      #2;
      chk($sformatf("tbl%0d_read_head", i), 64'(read_head), 64'(tbl[i].rh));
      chk($sformatf("tbl%0d_st_valid", i), 64'(st_valid), 64'(tbl[i].sv));
      chk($sformatf("tbl%0d_st_idx", i), 64'(st_idx), 64'(i + 3));
      exp_cnt += 64'(tbl[i].rh[0]) + 64'(tbl[i].rh[1]);
      step();
      chk($sformatf("tbl%0d_instret", i), instret, exp_cnt);
    end

    // Store held off by the store buffer for three cycles.
    clr();
    v = 2'b11; st = 2'b01; head = 5'd9;
    for (int i = 0; i < 4; i++) begin
      rdy = (i == 3);
      #2;
      chk("stall_read_head", 64'(read_head), (i == 3) ? 64'd3 : 64'd0);
      chk("stall_st_valid", 64'(st_valid), 1);
      chk("stall_st_idx", 64'(st_idx), 9);
      step();
    end
    exp_cnt += 2;
    clr();
    #2;
    chk("stall_instret", instret, exp_cnt);

    // Serialising op acked cleanly after five request cycles.
    v = 2'b01; ser = 2'b01; pc0 = 40'h1000;
    #2;
    chk("ser_no_retire", 64'(read_head), 0);
    step();
    for (int i = 0; i < 5; i++) begin
      ack = (i == 4);
      #2;
      chk("ser_req", 64'(csr_req), 1);
      chk("ser_read_head", 64'(read_head), (i == 4) ? 64'd1 : 64'd0);
      step();
    end
    exp_cnt += 1;
    clr();
    #2;
    chk("ser_flush", 64'(flush), 1);
    chk("ser_rvalid", 64'(rvalid), 1);
    chk("ser_redirect", 64'(rpc), 64'h1004);
    chk("ser_trap", 64'(trap), 0);
    chk("ser_req_drop", 64'(csr_req), 0);
    chk("ser_instret", instret, exp_cnt);
    step();
    #2;
    chk("ser_flush_end", 64'(flush), 0);

    // Exception at the head of the list.
    step();
    v = 2'b11; ex = 2'b01; cause = 6'd13; tvec = 40'h8000;
    #2;
    chk("exc_read_head", 64'(read_head), 0);
    step();
    clr();
    #2;
    chk("exc_flush", 64'(flush), 1);
    chk("exc_trap", 64'(trap), 1);
    chk("exc_cause", 64'(tcause), 13);
    chk("exc_redirect", 64'(rpc), 64'h8000);
    step();
    #2;
    chk("exc_trap_clear", 64'(trap), 0);
    chk("exc_cause_clear", 64'(tcause), 0);
    chk("exc_rvalid_clear", 64'(rvalid), 0);

    // Serialising op that faults.
    step();
    v = 2'b01; ser = 2'b01; pc0 = 40'h2000;
    step();
    ack = 1'b1; xcpt = 1'b1; tvec = 40'h44_0000_0040;
    #2;
    chk("sx_read_head", 64'(read_head), 0);
    step();
    clr();
    #2;
    chk("sx_flush", 64'(flush), 1);
    chk("sx_trap", 64'(trap), 1);
    chk("sx_cause", 64'(tcause), 2);
    chk("sx_redirect", 64'(rpc), 64'h44_0000_0040);
    chk("sx_instret", instret, exp_cnt);
    step();

    // Reset asserted while waiting for the CSR acknowledge.
    v = 2'b01; ser = 2'b01;
    step();
    #2;
    chk("rw_req_before", 64'(csr_req), 1);
    rstn = 1'b0;
    #1;
    chk("rw_req_async", 64'(csr_req), 0);
    chk("rw_flush_async", 64'(flush), 0);
    clr();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_cnt = 0;
    #2;
    chk("rw_instret", instret, 0);
    v = 2'b01;
    #1;
    chk("rw_run_retire", 64'(read_head), 1);
    step();
    exp_cnt = 1;
    clr();

    // Random traffic against the behavioural model.
    m_wait = 1'b0; m_flush = 1'b0; m_trap = 1'b0; m_cause = '0; m_target = '0;
    for (int c = 0; c < 3000; c++) begin
      v      = 2'($urandom);
      st     = 2'($urandom);
      ser    = {($urandom % 4) == 0, ($urandom % 6) == 0};
      ex     = {($urandom % 4) == 0, ($urandom % 10) == 0};
      cause  = 6'($urandom);
      pc0    = (($urandom % 8) == 0) ? {8'hFF, 32'hFFFF_FFFC} : {8'($urandom), 32'($urandom)};
      pc1    = {8'($urandom), 32'($urandom)};
      tvec   = {8'($urandom), 32'($urandom)};
      head   = IW'($urandom);
      rdy    = 1'($urandom);
      ack    = ($urandom % 4) == 0;
      xcpt   = 1'($urandom);
      if (m_wait) begin
        v[0] = 1'b1; ser[0] = 1'b1; ex[0] = 1'b0;
      end
      #2;
      if (m_flush)
        n_ret = 0;
      else if (m_wait)
        n_ret = (ack && !xcpt) ? 1 : 0;
      else if (v[0] && !ex[0] && !ser[0] && (!st[0] || rdy))
        n_ret = (v[1] && !(st[1] || ser[1] || ex[1])) ? 2 : 1;
      else
        n_ret = 0;
      chk("rnd_retire_count", 64'(read_head[0]) + 64'(read_head[1]), 64'(n_ret));
      chk("rnd_retire_shape", 64'(read_head == 2'b10), 0);
      chk("rnd_st_valid", 64'(st_valid),
          64'(!m_flush && v[0] && st[0] && !ex[0] && !ser[0]));
      chk("rnd_st_idx", 64'(st_idx), 64'(head));
      chk("rnd_csr_req", 64'(csr_req), 64'(m_wait));
      chk("rnd_flush", 64'(flush), 64'(m_flush));
      chk("rnd_rvalid", 64'(rvalid), 64'(m_flush));
      chk("rnd_trap", 64'(trap), 64'(m_flush && m_trap));
      chk("rnd_cause", 64'(tcause), m_flush ? 64'(m_cause) : 64'd0);
      chk("rnd_redirect", 64'(rpc), m_flush ? 64'(m_target) : 64'd0);
      chk("rnd_instret", instret, exp_cnt);
      exp_cnt += 64'(n_ret);
      if (m_flush) begin
        m_flush = 1'b0;
      end else if (m_wait) begin
        if (ack) begin
          m_wait  = 1'b0;
          m_flush = 1'b1;
          m_trap  = xcpt;
          m_cause = xcpt ? 6'd2 : 6'd0;
          m_target = xcpt ? tvec : pc0 + 40'd4;
        end
      end else if (v[0] && ex[0]) begin
        m_flush = 1'b1; m_trap = 1'b1; m_cause = cause; m_target = tvec;
      end else if (v[0] && ser[0]) begin
        m_wait = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
